// File: rtl/board_pkt_rx.sv
// Inter-board link receiver: oversampled 8N1 UART that assembles PKT_LEN-bit packets
// from consecutive bytes and presents each completed packet with a one-cycle ready strobe.
module board_pkt_rx #(
    parameter int CLK_PER_SAMP  = 423,
    parameter int SAMP_PER_BIT  = 16,
    parameter int PKT_LEN       = 208,
    parameter int WAITING_COUNT = 130_000
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rx,
    output logic [PKT_LEN-1:0] data_out,
    output logic               ready,
    output logic               err
);

    localparam int NBYTES = PKT_LEN / 8;
    localparam int SCW    = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
    localparam int TCW    = (SAMP_PER_BIT > 2) ? $clog2(SAMP_PER_BIT) : 1;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int GCW    = $clog2(WAITING_COUNT + 1);

    localparam logic [SCW-1:0] SAMP_LAST = SCW'(CLK_PER_SAMP - 1);
    localparam logic [TCW-1:0] HALF_LAST = TCW'(SAMP_PER_BIT / 2 - 1);
    localparam logic [TCW-1:0] BIT_LAST  = TCW'(SAMP_PER_BIT - 1);
    localparam logic [BCW-1:0] BYTE_LAST = BCW'(NBYTES - 1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'(WAITING_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic                 rx_meta_r, rxs_r;
    logic [SCW-1:0]       samp_cnt_r, samp_cnt_s;
    logic [TCW-1:0]       tick_cnt_r, tick_cnt_s;
    logic [2:0]           bit_idx_r, bit_idx_s;
    logic [7:0]           shift_r, shift_s;
    logic [BCW-1:0]       byte_cnt_r, byte_cnt_s;
    logic [GCW-1:0]       gap_cnt_r, gap_cnt_s;
    logic [PKT_LEN-1:0]   buf_r, buf_s;
    logic [PKT_LEN-1:0]   data_r, data_s;
    logic                 ready_r, ready_s;
    logic                 err_r, err_s;
    logic                 tick_s;

    // Two-flop synchronizer for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rxs_r     <= rx_meta_r;
        end
    end

    // Next-state and datapath decode for the receive FSM, tick generator and gap timer.
    always_comb begin
        state_s    = state_r;
        tick_cnt_s = tick_cnt_r;
        bit_idx_s  = bit_idx_r;
        shift_s    = shift_r;
        byte_cnt_s = byte_cnt_r;
        gap_cnt_s  = gap_cnt_r;
        buf_s      = buf_r;
        data_s     = data_r;
        ready_s    = 1'b0;
        err_s      = 1'b0;
        tick_s     = (samp_cnt_r == SAMP_LAST);
        if (tick_s) begin
            samp_cnt_s = {SCW{1'b0}};
        end else begin
            samp_cnt_s = samp_cnt_r + SCW'(1);
        end

        case (state_r)
            ST_IDLE: begin
                tick_cnt_s = {TCW{1'b0}};
                if (!rxs_r) begin
                    // Re-phase the tick counter to the start edge.
                    state_s    = ST_START;
                    samp_cnt_s = {SCW{1'b0}};
                    gap_cnt_s  = {GCW{1'b0}};
                end else if (byte_cnt_r != {BCW{1'b0}}) begin
                    if (gap_cnt_r == GAP_LAST) begin
                        err_s      = 1'b1;
                        byte_cnt_s = {BCW{1'b0}};
                        gap_cnt_s  = {GCW{1'b0}};
                    end else begin
                        gap_cnt_s = gap_cnt_r + GCW'(1);
                    end
                end else begin
                    gap_cnt_s = {GCW{1'b0}};
                end
            end
            ST_START: begin
                if (tick_s && (tick_cnt_r == HALF_LAST)) begin
                    tick_cnt_s = {TCW{1'b0}};
                    bit_idx_s  = 3'd0;
                    if (!rxs_r) begin
                        state_s = ST_DATA;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (tick_s) begin
                    tick_cnt_s = tick_cnt_r + TCW'(1);
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            ST_DATA: begin
                if (tick_s && (tick_cnt_r == BIT_LAST)) begin
                    tick_cnt_s         = {TCW{1'b0}};
                    shift_s[bit_idx_r] = rxs_r;
                    if (bit_idx_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else if (tick_s) begin
                    tick_cnt_s = tick_cnt_r + TCW'(1);
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            ST_STOP: begin
                if (tick_s && (tick_cnt_r == BIT_LAST)) begin
                    tick_cnt_s = {TCW{1'b0}};
                    state_s    = ST_IDLE;
                    if (rxs_r) begin
                        buf_s[{byte_cnt_r, 3'b000} +: 8] = shift_r;
                        if (byte_cnt_r == BYTE_LAST) begin
                            data_s     = buf_s;
                            ready_s    = 1'b1;
                            byte_cnt_s = {BCW{1'b0}};
                        end else begin
                            byte_cnt_s = byte_cnt_r + BCW'(1);
                        end
                    end else begin
                        err_s      = 1'b1;
                        byte_cnt_s = {BCW{1'b0}};
                    end
                end else if (tick_s) begin
                    tick_cnt_s = tick_cnt_r + TCW'(1);
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial byte and packet silently.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r    <= ST_IDLE;
            samp_cnt_r <= {SCW{1'b0}};
            tick_cnt_r <= {TCW{1'b0}};
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            byte_cnt_r <= {BCW{1'b0}};
            gap_cnt_r  <= {GCW{1'b0}};
            buf_r      <= {PKT_LEN{1'b0}};
            data_r     <= {PKT_LEN{1'b0}};
            ready_r    <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            samp_cnt_r <= samp_cnt_s;
            tick_cnt_r <= tick_cnt_s;
            bit_idx_r  <= bit_idx_s;
            shift_r    <= shift_s;
            byte_cnt_r <= byte_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
            buf_r      <= buf_s;
            data_r     <= data_s;
            ready_r    <= ready_s;
            err_r      <= err_s;
        end
    end

    assign data_out = data_r;
    assign ready    = ready_r;
    assign err      = err_r;

endmodule

// File: tb/tb_board_pkt_rx.sv
// Scoreboard bench for board_pkt_rx: drives 8N1 frames on rx and checks each ready
// against queued packets, plus error pulses, timeout latency and reset behaviour.
module tb_board_pkt_rx;

    localparam int CPS    = 4;
    localparam int SPB    = 16;
    localparam int PL     = 16;
    localparam int WC     = 2000;
    localparam int BITCLK = CPS * SPB;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          rx     = 1'b1;
    logic [PL-1:0] data_out;
    logic          ready;
    logic          err;

    int            n_checks   = 0;
    int            n_errors   = 0;
    int            seen_err   = 0;
    int            exp_err    = 0;
    longint        cyc        = 0;
    longint        err_cyc    = 0;
    longint        t0         = 0;
    logic [PL-1:0] exp_q[$];
    logic [PL-1:0] model_data = '0;
    logic [PL-1:0] popped;

    board_pkt_rx #(
        .CLK_PER_SAMP (CPS),
        .SAMP_PER_BIT (SPB),
        .PKT_LEN      (PL),
        .WAITING_COUNT(WC)
    ) dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rx      (rx),
        .data_out(data_out),
        .ready   (ready),
        .err     (err)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on ready, tracks err pulses.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            model_data = '0;
        end else begin
            if (ready) begin
                check("ready_err_excl", 32'(ready & err), 32'd0);
                check("ready_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    popped = exp_q.pop_front();
                    check("data_out", 32'(data_out), 32'(popped));
                    model_data = popped;
                end
            end
            if (err) begin
                seen_err++;
                err_cyc = cyc;
                check("err_data_hold", 32'(data_out), 32'(model_data));
            end
        end
    end

    task automatic hold(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        hold(1'b0, BITCLK);
        for (int i = 0; i < 8; i++) hold(b[i], BITCLK);
        hold(stop, BITCLK);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1);
        send_frame(b0, 1'b1);
        exp_q.push_back({b1, b0});
        send_frame(b1, 1'b1);
    endtask

    task automatic end_test(input string tag);
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk_in);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_errcnt"}, 32'(seen_err), 32'(exp_err));
    endtask

    initial begin
        @(negedge clk_in);
        hold(1'b1, 5);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_in = 1'b1;
        hold(1'b1, 10);

        // 1: good packet, back to back
        send_pkt(8'hA5, 8'h3C);
        hold(1'b1, 20);
        end_test("good");

        // 2: two packets, all four bytes back to back
        send_pkt(8'h5A, 8'h01);
        send_pkt(8'hFF, 8'h00);
        hold(1'b1, 20);
        end_test("two");

        // 3: false start glitch
        hold(1'b0, 20);
        hold(1'b1, 100);
        send_pkt(8'h11, 8'h22);
        hold(1'b1, 20);
        end_test("false_start");

        // 4: framing error then good packet
        send_frame(8'h12, 1'b0);
        exp_err++;
        hold(1'b1, BITCLK);
        send_pkt(8'h34, 8'h56);
        hold(1'b1, 20);
        end_test("framing");

        // 5: gap timeout
        send_frame(8'h77, 1'b1);
        t0 = cyc;
        exp_err++;
        hold(1'b1, 2100);
        check("timeout_window", 32'((err_cyc - t0 >= 1950) && (err_cyc - t0 <= 1995)), 32'd1);
        send_pkt(8'h88, 8'h99);
        hold(1'b1, 20);
        end_test("timeout");

        // 6: reset midway through the second byte
        send_frame(8'h77, 1'b1);
        hold(1'b0, BITCLK);
        hold(1'b1, BITCLK);
        hold(1'b0, BITCLK);
        hold(1'b1, BITCLK / 2);
        rst_in = 1'b0;
        rx     = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        check("rst2_data", 32'(data_out), 32'd0);
        check("rst2_ready", 32'(ready), 32'd0);
        check("rst2_err", 32'(err), 32'd0);
        hold(1'b1, 2 * BITCLK);
        send_pkt(8'hAB, 8'hCD);
        hold(1'b1, 20);
        end_test("reset_mid");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
